// File: rtl/sid_audio_pkg.sv
// sid_audio_pkg: shared widths, modulator feedback levels, ramp states and a saturating clamp
package sid_audio_pkg;
  localparam int SOUND_W = 19;
  localparam int SAMPLE_W = 16;
  localparam int INT_W = 22;
  localparam int FB_POS = 32767;
  localparam int FB_NEG = -32768;
  typedef enum logic {HOLD, RAMP} ramp_t;
  function automatic int sat_n(input int x, input int n);
    int hi;
    hi = (1 << (n - 1)) - 1;
    return x > hi ? hi : x < -hi - 1 ? -hi - 1 : x;
  endfunction
endpackage

// File: rtl/sid_dsm2.sv
// sid_dsm2: tick-gated 2nd-order 1-bit delta-sigma modulator (clk, rst, tick, sample -> audio_out)
module sid_dsm2 import sid_audio_pkg::*; (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic signed [SAMPLE_W-1:0] sample,
  output logic                       audio_out
);
  logic signed [INT_W-1:0] i1, i2;
  int fb, i1_n, i2_n;
  always_comb begin
    fb = audio_out ? FB_POS : FB_NEG;
    i1_n = sat_n(int'(i1) + int'(sample) - fb, INT_W);
    i2_n = sat_n(int'(i2) + int'(i1) - fb, INT_W);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      i1 <= '0;
      i2 <= '0;
      audio_out <= 1'b0;
    end else if (tick) begin
      i1 <= INT_W'(i1_n);
      i2 <= INT_W'(i2_n);
      audio_out <= i2_n >= 0;
    end
endmodule

// File: rtl/sid_dac_out.sv
// sid_dac_out: capture/scale/saturate mixer samples, sticky clip, linear ramp into sid_dsm2 (sound_in/valid, clip_clear -> audio_out, sample_out, clip)
module sid_dac_out import sid_audio_pkg::*; #(
  parameter int SHIFT = 2,
  parameter int RAMP_LOG2 = 4,
  parameter int CLK_DIV = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [SOUND_W-1:0]  sound_in,
  input  logic                       sound_valid,
  input  logic                       clip_clear,
  output logic                       audio_out,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       clip
);
  localparam logic [RAMP_LOG2:0] RLEN = (RAMP_LOG2 + 1)'(1) << RAMP_LOG2;
  ramp_t state, state_n;
  logic [7:0] pre;
  logic tick, clipped;
  logic signed [SOUND_W-1:0] shifted;
  int sat;
  logic signed [SAMPLE_W-1:0] tgt_new, target, target_n, sample_n;
  logic signed [SAMPLE_W:0] diff, step, step_n;
  logic [RAMP_LOG2:0] rcnt, rcnt_n;
  assign tick = pre == 8'(CLK_DIV - 1);
  assign shifted = sound_in >>> SHIFT;
  assign sat = sat_n(int'(shifted), SAMPLE_W);
  assign clipped = sat != int'(shifted);
  assign tgt_new = SAMPLE_W'(sat);
  assign diff = {tgt_new[SAMPLE_W-1], tgt_new} - {sample_out[SAMPLE_W-1], sample_out};
  // a capture always wins over a coincident tick; the last tick lands exactly on target
  always_comb begin
    state_n = state;
    sample_n = sample_out;
    target_n = target;
    step_n = step;
    rcnt_n = rcnt;
    if (sound_valid) begin
      target_n = tgt_new;
      step_n = diff >>> RAMP_LOG2;
      rcnt_n = RLEN;
      state_n = RAMP_LOG2 == 0 ? HOLD : RAMP;
      sample_n = RAMP_LOG2 == 0 ? tgt_new : sample_out;
    end else if (state == RAMP && tick) begin
      state_n = rcnt == (RAMP_LOG2 + 1)'(1) ? HOLD : RAMP;
      sample_n = rcnt == (RAMP_LOG2 + 1)'(1) ? target : SAMPLE_W'({sample_out[SAMPLE_W-1], sample_out} + step);
      rcnt_n = rcnt - 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= HOLD;
      pre <= '0;
      sample_out <= '0;
      target <= '0;
      step <= '0;
      rcnt <= '0;
      clip <= 1'b0;
    end else begin
      state <= state_n;
      pre <= tick ? 8'd0 : pre + 8'd1;
      sample_out <= sample_n;
      target <= target_n;
      step <= step_n;
      rcnt <= rcnt_n;
      clip <= (sound_valid && clipped) || (clip && !clip_clear);
    end
  sid_dsm2 u_dsm (.clk(clk), .rst(rst), .tick(tick), .sample(sample_out), .audio_out(audio_out));
endmodule

// File: tb/tb_sid_dac_out.sv
// tb_sid_dac_out: scoreboard bench for sid_dac_out (ramp, clip, retrigger, reset, density, immediate mode)
module tb_sid_dac_out;
  localparam int SHIFT = 2;
  localparam int RAMP_LOG2 = 4;
  localparam int CLK_DIV = 2;
  logic clk = 1'b0, rst, sound_valid, clip_clear;
  logic signed [18:0] sound_in;
  logic audio_out, clip, imm_audio, imm_clip;
  logic signed [15:0] sample_out, imm_sample;
  int checks = 0, failures = 0, pre_m = 0, m_cur = 0, m_clip = 0, ones = 0;
  int q[$];
  always #5 clk = ~clk;
  sid_dac_out #(.SHIFT(SHIFT), .RAMP_LOG2(RAMP_LOG2), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .sound_in(sound_in), .sound_valid(sound_valid), .clip_clear(clip_clear),
    .audio_out(audio_out), .sample_out(sample_out), .clip(clip));
  sid_dac_out #(.SHIFT(SHIFT), .RAMP_LOG2(0), .CLK_DIV(1)) dut_imm (
    .clk(clk), .rst(rst), .sound_in(sound_in), .sound_valid(sound_valid), .clip_clear(clip_clear),
    .audio_out(imm_audio), .sample_out(imm_sample), .clip(imm_clip));
  task automatic chk(input string tag, input int got, input int exp, input int tol = 0);
    checks++;
    if (got < exp - tol || got > exp + tol) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d tol=%0d", tag, got, exp, tol);
    end
  endtask
  task automatic cyc(input bit cap = 0);
    bit t;
    t = pre_m == CLK_DIV - 1;
    @(posedge clk);
    #1;
    pre_m = t ? 0 : pre_m + 1;
    if (t) begin
      ones += int'(audio_out);
      if (!cap && q.size() > 0) m_cur = q.pop_front();
      chk("tick_sample", sample_out, m_cur);
    end
  endtask
  task automatic run_ticks(input int n);
    int k = 0;
    while (k < n) begin
      if (pre_m == CLK_DIV - 1) k++;
      cyc();
    end
  endtask
  task automatic capture(input int v, input bit clr, input bit on_tick = 0);
    int s, t, st;
    s = v >>> SHIFT;
    t = s > 32767 ? 32767 : s < -32768 ? -32768 : s;
    if (on_tick) while (pre_m != CLK_DIV - 1) cyc();
    sound_in = 19'(v);
    sound_valid = 1'b1;
    clip_clear = clr;
    cyc(1);
    sound_valid = 1'b0;
    clip_clear = 1'b0;
    m_clip = t != s ? 1 : clr ? 0 : m_clip;
    st = (t - m_cur) >>> RAMP_LOG2;
    q.delete();
    for (int k = 1; k < (1 << RAMP_LOG2); k++) q.push_back(m_cur + k * st);
    q.push_back(t);
    chk("cap_clip", int'(clip), m_clip);
    chk("imm_sample", imm_sample, t);
    chk("cap_hold", sample_out, m_cur);
  endtask
  task automatic clear_clip();
    clip_clear = 1'b1;
    cyc();
    clip_clear = 1'b0;
    m_clip = 0;
    chk("clip_clear", int'(clip), m_clip);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_audio", int'(audio_out), 0);
    chk("rst_sample", sample_out, 0);
    chk("rst_clip", int'(clip), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pre_m = 0;
    m_cur = 0;
    m_clip = 0;
    q.delete();
  endtask
  task automatic density(input string tag, input int n, input int exp, input int tol);
    ones = 0;
    run_ticks(n);
    chk(tag, ones, exp, tol);
  endtask
  initial begin
    rst = 1'b1;
    sound_in = '0;
    sound_valid = 1'b0;
    clip_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    run_ticks(8);
    capture(80000, 0);
    run_ticks(1);
    chk("ramp_first", sample_out, 1250);
    run_ticks(1);
    chk("ramp_second", sample_out, 2500);
    run_ticks(14);
    chk("ramp_end", sample_out, 20000);
    run_ticks(4);
    chk("ramp_noclip", int'(clip), 0);
    capture(262143, 0);
    run_ticks(18);
    chk("clip_hi_val", sample_out, 32767);
    clear_clip();
    capture(-262144, 0);
    run_ticks(18);
    chk("clip_lo_val", sample_out, -32768);
    capture(262143, 1);
    chk("clip_set_wins", int'(clip), 1);
    run_ticks(18);
    clear_clip();
    capture(0, 0);
    run_ticks(18);
    capture(80000, 0);
    run_ticks(5);
    chk("retrig_pre", sample_out, 6250);
    capture(0, 0, 1);
    run_ticks(1);
    chk("retrig_step", sample_out, 6250 - 391);
    run_ticks(15);
    chk("retrig_end", sample_out, 0);
    capture(-4000, 0);
    chk("imm_m4000", imm_sample, -1000);
    run_ticks(18);
    capture(80000, 0);
    run_ticks(3);
    do_reset();
    run_ticks(8);
    density("dens_0", 1024, 512, 2);
    capture(65536, 0);
    run_ticks(80);
    density("dens_16384", 1024, 768, 4);
    capture(131068, 0);
    run_ticks(80);
    chk("clip_full_scale", int'(clip), 0);
    density("dens_full", 4096, 4096, 16);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
